addr2_sel_gen: RTL and testbench

- Front end of the address path. Takes a fetched instruction word plus the PC and base-register values.
- Decodes which ADDR2 offset the instruction uses, sign-extends it, and drives the 2-bit ADDR2 select in the datapath's Gray-ordered code (00 = zero, 01 = offset6, 11 = offset11, 10 = offset9).
- Also produces the effective address (base + offset).
- Two-stage registered pipeline with valid/ready handshakes on both sides. It feeds the ADDR2 mux select line and the MAR/PC load path.

---
 rtl/addr2_sel_gen_if.sv | 47 ++++
 rtl/addr2_sel_gen.sv | 184 ++++++++++++++++++
 tb/tb_addr2_sel_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/addr2_sel_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : addr2_sel_gen_if
//  Description : Handshake/data bundle for the ADDR2 select generator.
//                The slave modport is the DUT view; the master modport is the
//                view of whoever drives instructions and consumes results.
//                The err signal exists only when ADDR2_ERR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface addr2_sel_gen_if #(
    parameter int DATA_W = 16
) ();
    // Input side
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       ir;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] baser;
    // Output side
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        select;
    logic [DATA_W-1:0] offset;
    logic              base_sel;
    logic [DATA_W-1:0] ea;
    logic              addr_used;
`ifdef ADDR2_ERR_EN
    logic              err;
`endif

    modport slave (
        input  in_valid, ir, pc, baser, out_ready,
        output in_ready, out_valid, select, offset, base_sel, ea, addr_used
`ifdef ADDR2_ERR_EN
        , output err
`endif
    );

    modport master (
        output in_valid, ir, pc, baser, out_ready,
        input  in_ready, out_valid, select, offset, base_sel, ea, addr_used
`ifdef ADDR2_ERR_EN
        , input err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/addr2_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : addr2_sel_gen
//  Description : Two-stage pipeline that decodes the ADDR2 offset from an
//                instruction, drives the Gray-ordered ADDR2 select
//                (00 zero, 01 off6, 11 off11, 10 off9), the ADDR1 base select
//                and the effective address base + offset.
//                Optional macro ADDR2_ERR_EN adds an err flag for the RTI and
//                reserved opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr2_sel_gen #(
    parameter int DATA_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    addr2_sel_gen_if.slave      bus
);

    localparam logic [1:0] c_SEL_ZERO  = 2'b00;
    localparam logic [1:0] c_SEL_OFF6  = 2'b01;
    localparam logic [1:0] c_SEL_OFF11 = 2'b11;
    localparam logic [1:0] c_SEL_OFF9  = 2'b10;

    // ------------------------------------------------------------------------
    // Decode wires
    // ------------------------------------------------------------------------
    logic [3:0]        w_opc;
    logic [1:0]        w_select;
    logic [DATA_W-1:0] w_offset;
    logic              w_base_sel;
    logic              w_addr_used;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_sext6;
    logic [DATA_W-1:0] w_sext9;
    logic [DATA_W-1:0] w_sext11;
`ifdef ADDR2_ERR_EN
    logic              w_err;
`endif

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic              r_s1_valid;
    logic [1:0]        r_s1_select;
    logic [DATA_W-1:0] r_s1_offset;
    logic              r_s1_base_sel;
    logic              r_s1_addr_used;
    logic [DATA_W-1:0] r_s1_base;

    logic              r_s2_valid;
    logic [1:0]        r_s2_select;
    logic [DATA_W-1:0] r_s2_offset;
    logic              r_s2_base_sel;
    logic              r_s2_addr_used;
    logic [DATA_W-1:0] r_s2_ea;
`ifdef ADDR2_ERR_EN
    logic              r_s1_err;
    logic              r_s2_err;
`endif

    logic              w_adv1;
    logic              w_adv2;

    assign w_opc    = bus.ir[15:12];
    assign w_sext6  = {{(DATA_W-6){bus.ir[5]}},   bus.ir[5:0]};
    assign w_sext9  = {{(DATA_W-9){bus.ir[8]}},   bus.ir[8:0]};
    assign w_sext11 = {{(DATA_W-11){bus.ir[10]}}, bus.ir[10:0]};

    // A stage may advance when its successor is empty or is draining.
    assign w_adv2      = !r_s2_valid || bus.out_ready;
    assign w_adv1      = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1;

    // Opcode decode: offset width, base choice and adder usage.
    always_comb begin
        w_select    = c_SEL_ZERO;
        w_offset    = '0;
        w_base_sel  = 1'b0;
        w_addr_used = 1'b0;
        case (w_opc)
            4'b0000, 4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b1110: begin
                w_select    = c_SEL_OFF9;
                w_offset    = w_sext9;
                w_addr_used = 1'b1;
            end
            4'b0100: begin
                w_addr_used = 1'b1;
                if (bus.ir[11]) begin
                    w_select = c_SEL_OFF11;
                    w_offset = w_sext11;
                end else begin
                    w_base_sel = 1'b1;
                end
            end
            4'b1100: begin
                w_base_sel  = 1'b1;
                w_addr_used = 1'b1;
            end
            4'b0110, 4'b0111: begin
                w_select    = c_SEL_OFF6;
                w_offset    = w_sext6;
                w_base_sel  = 1'b1;
                w_addr_used = 1'b1;
            end
            default: begin
                w_select    = c_SEL_ZERO;
            end
        endcase
    end

`ifdef ADDR2_ERR_EN
    // RTI and the reserved opcode are flagged but otherwise pass as no-ops.
    assign w_err = (w_opc == 4'b1101) || (w_opc == 4'b1000);
`endif

    assign w_base = w_base_sel ? bus.baser : bus.pc;

    // Stage 1: capture the decoded fields and the chosen base on input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_select    <= c_SEL_ZERO;
            r_s1_offset    <= '0;
            r_s1_base_sel  <= 1'b0;
            r_s1_addr_used <= 1'b0;
            r_s1_base      <= '0;
`ifdef ADDR2_ERR_EN
            r_s1_err       <= 1'b0;
`endif
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_select    <= w_select;
                r_s1_offset    <= w_offset;
                r_s1_base_sel  <= w_base_sel;
                r_s1_addr_used <= w_addr_used;
                r_s1_base      <= w_base;
`ifdef ADDR2_ERR_EN
                r_s1_err       <= w_err;
`endif
            end
        end
    end

    // Stage 2: form the effective address (silent wrap) and carry the fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid     <= 1'b0;
            r_s2_select    <= c_SEL_ZERO;
            r_s2_offset    <= '0;
            r_s2_base_sel  <= 1'b0;
            r_s2_addr_used <= 1'b0;
            r_s2_ea        <= '0;
`ifdef ADDR2_ERR_EN
            r_s2_err       <= 1'b0;
`endif
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_select    <= r_s1_select;
                r_s2_offset    <= r_s1_offset;
                r_s2_base_sel  <= r_s1_base_sel;
                r_s2_addr_used <= r_s1_addr_used;
                r_s2_ea        <= r_s1_base + r_s1_offset;
`ifdef ADDR2_ERR_EN
                r_s2_err       <= r_s1_err;
`endif
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.select    = r_s2_select;
    assign bus.offset    = r_s2_offset;
    assign bus.base_sel  = r_s2_base_sel;
    assign bus.addr_used = r_s2_addr_used;
    assign bus.ea        = r_s2_ea;
`ifdef ADDR2_ERR_EN
    assign bus.err       = r_s2_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addr2_sel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr2_sel_gen
//  Description : Self-checking bench for addr2_sel_gen: directed vector table
//                plus back-pressure, throughput and mid-stream reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr2_sel_gen;

    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    addr2_sel_gen_if #(.DATA_W(DATA_W)) bus ();

    addr2_sel_gen #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] baser;
        logic [1:0]  e_sel;
        logic [15:0] e_off;
        logic        e_bsel;
        logic [15:0] e_ea;
        logic        e_used;
        logic        e_err;
    } vec_t;

    vec_t vecs [14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int idx;
        int outidx;
        logic xfer_in;
        logic [15:0] held_ea;

        n_checks = 0;
        n_errors = 0;

        //          ir        pc        baser     sel    off       bsel  ea        used  err
        vecs[0]  = '{16'h6A3F, 16'h0000, 16'h3000, 2'b01, 16'hFFFF, 1'b1, 16'h2FFF, 1'b1, 1'b0}; // LDR -1
        vecs[1]  = '{16'h0E01, 16'hFFFF, 16'h0000, 2'b10, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0}; // BR wrap
        vecs[2]  = '{16'h4FFE, 16'h3001, 16'h0000, 2'b11, 16'hFFFE, 1'b0, 16'h2FFF, 1'b1, 1'b0}; // JSR
        vecs[3]  = '{16'h4080, 16'h1111, 16'h4000, 2'b00, 16'h0000, 1'b1, 16'h4000, 1'b1, 1'b0}; // JSRR
        vecs[4]  = '{16'hC1C0, 16'h2222, 16'h1234, 2'b00, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0}; // RET
        vecs[5]  = '{16'h21FF, 16'h0100, 16'h9999, 2'b10, 16'hFFFF, 1'b0, 16'h00FF, 1'b1, 1'b0}; // LD -1
        vecs[6]  = '{16'hE0FF, 16'h3000, 16'h0000, 2'b10, 16'h00FF, 1'b0, 16'h30FF, 1'b1, 1'b0}; // LEA
        vecs[7]  = '{16'h7020, 16'h8888, 16'h0010, 2'b01, 16'hFFE0, 1'b1, 16'hFFF0, 1'b1, 1'b0}; // STR -32
        vecs[8]  = '{16'h1000, 16'h5555, 16'hAAAA, 2'b00, 16'h0000, 1'b0, 16'h5555, 1'b0, 1'b0}; // ADD
        vecs[9]  = '{16'hD000, 16'h0000, 16'h7777, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1}; // reserved
        vecs[10] = '{16'h8000, 16'h0123, 16'h7777, 2'b00, 16'h0000, 1'b0, 16'h0123, 1'b0, 1'b1}; // RTI
        vecs[11] = '{16'hB1FF, 16'h0001, 16'h0000, 2'b10, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0}; // STI wrap
        vecs[12] = '{16'h3100, 16'h0200, 16'h0000, 2'b10, 16'hFF00, 1'b0, 16'h0100, 1'b1, 1'b0}; // ST -256
        vecs[13] = '{16'hA0FF, 16'h1000, 16'h0000, 2'b10, 16'h00FF, 1'b0, 16'h10FF, 1'b1, 1'b0}; // LDI

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ir        = '0;
        bus.pc        = '0;
        bus.baser     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_select",    bus.select,    0);
        chk("rst_offset",    bus.offset,    0);
        chk("rst_ea",        bus.ea,        0);
        chk("rst_base_sel",  bus.base_sel,  0);
        chk("rst_addr_used", bus.addr_used, 0);
`ifdef ADDR2_ERR_EN
        chk("rst_err",       bus.err,       0);
`endif

        // Directed table: one instruction at a time, checked two edges later.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("vec_in_ready", bus.in_ready, 1);
            bus.ir       = vecs[i].ir;
            bus.pc       = vecs[i].pc;
            bus.baser    = vecs[i].baser;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_select", i),    bus.select,    vecs[i].e_sel);
            chk($sformatf("v%0d_offset", i),    bus.offset,    vecs[i].e_off);
            chk($sformatf("v%0d_base_sel", i),  bus.base_sel,  vecs[i].e_bsel);
            chk($sformatf("v%0d_ea", i),        bus.ea,        vecs[i].e_ea);
            chk($sformatf("v%0d_addr_used", i), bus.addr_used, vecs[i].e_used);
`ifdef ADDR2_ERR_EN
            chk($sformatf("v%0d_err", i),       bus.err,       vecs[i].e_err);
`endif
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", bus.out_valid, 0);

        // Back-pressure: 4 LDs (offset k+1, pc 1000) with the consumer stalled.
        bus.out_ready = 1'b0;
        bus.pc        = 16'h1000;
        idx           = 0;
        held_ea       = '0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (idx < 4);
            bus.ir       = 16'h2001 + 16'(idx);
            @(negedge clk);
            xfer_in = bus.in_valid && bus.in_ready;
            if (c == 3) held_ea = bus.ea;
            @(posedge clk);
            #1;
            if (xfer_in) idx++;
        end
        chk("bp_transfers",  idx,           2);
        chk("bp_in_ready",   bus.in_ready,  0);
        chk("bp_out_valid",  bus.out_valid, 1);
        chk("bp_ea_first",   bus.ea,        16'h1001);
        chk("bp_ea_stable",  bus.ea,        held_ea);
        chk("bp_offset",     bus.offset,    16'h0001);
        chk("bp_select",     bus.select,    2'b10);

        // Release: remaining inputs flow in while all four emerge back-to-back.
        bus.out_ready = 1'b1;
        outidx        = 0;
        for (int c = 0; c < 20 && outidx < 4; c++) begin
            bus.in_valid = (idx < 4);
            bus.ir       = 16'h2001 + 16'(idx);
            @(negedge clk);
            xfer_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                chk($sformatf("bp_out%0d_ea", outidx), bus.ea, 16'h1001 + 16'(outidx));
                outidx++;
            end else if (outidx > 0) begin
                chk("bp_no_bubble", bus.out_valid, 1);
            end
            @(posedge clk);
            #1;
            if (xfer_in) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_outputs_seen", outidx, 4);
        @(negedge clk);
        chk("bp_empty", bus.out_valid, 0);

        // Mid-stream reset: two items in flight, pulse reset, nothing emerges.
        bus.out_ready = 1'b0;
        bus.ir        = 16'h6A3F;
        bus.baser     = 16'h3000;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.ir = 16'h0E01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("mr_full_out_valid", bus.out_valid, 1);
        chk("mr_full_select",    bus.select,    2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_select",    bus.select,    0);
        chk("mr_ea",        bus.ea,        0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("mr_no_stale%0d", c), bus.out_valid, 0);
        end
        chk("mr_in_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
